mem_port_arbiter: RTL and testbench

- Sequences shared access to the single main-memory port between the instruction-cache refill side (I) and the data-cache refill/write-through side (D) of risc_v_processor.
- Runs block refills as BLOCK_WORDS-beat bursts and write-through stores as single beats.
- Arbitrates round-robin and aborts any stalled transfer on a watchdog timeout.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_watchdog.sv | 29 ++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the main-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_XFER  = 2'd1,
    D_XFER  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

  // Width of the beat index inside a block; never narrower than one bit.
  function automatic int beat_idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Stall watchdog: counts transfer cycles without mem_ready and flags the
// cycle in which the count reaches TIMEOUT.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign timeout = active && !ready && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!active || ready || timeout) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Main-memory port arbiter: round-robin between I-cache refills and D-cache
// refills/write-throughs, with burst sequencing and a stall watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int TIMEOUT     = 64,
  localparam int IW         = beat_idx_w(BLOCK_WORDS)
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic [IW-1:0]     i_word_idx,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic [IW-1:0]     d_word_idx,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  arb_state_t        state;
  requester_t        last_grant;
  logic [IW-1:0]     beat_cnt;
  logic [ADDR_W-1:2] word_addr;
  logic              we;
  logic [31:0]       wdata;
  logic              i_gnt_q;
  logic              d_gnt_q;
  logic              err_q;

  logic in_i, in_d, xfer, beat, last_beat, timeout, finish, pick_i;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  assign in_i      = (state == I_XFER);
  assign in_d      = (state == D_XFER);
  assign xfer      = in_i || in_d;
  assign beat      = xfer && mem_ready;
  assign last_beat = beat && (we || (beat_cnt == IW'(BLOCK_WORDS - 1)));
  assign finish    = last_beat || timeout;
  // On a conflict the side that did not win last time gets the port.
  assign pick_i    = i_req && (!d_req || (last_grant == REQ_D));

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (CLK),
    .rst     (rst),
    .active  (xfer),
    .ready   (mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= REQ_D;
      beat_cnt   <= '0;
      word_addr  <= '0;
      we         <= 1'b0;
      wdata      <= 32'd0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (pick_i) begin
            state      <= I_XFER;
            i_gnt_q    <= 1'b1;
            last_grant <= REQ_I;
            word_addr  <= i_addr[ADDR_W-1:2];
            we         <= 1'b0;
            wdata      <= 32'd0;
          end else if (d_req) begin
            state      <= D_XFER;
            d_gnt_q    <= 1'b1;
            last_grant <= REQ_D;
            word_addr  <= d_addr[ADDR_W-1:2];
            we         <= d_we;
            wdata      <= d_wdata;
          end
        end
        I_XFER, D_XFER: begin
          if (beat && !we) begin
            beat_cnt <= beat_cnt + IW'(1);
          end
          if (timeout) begin
            err_q <= 1'b1;
          end
          if (finish) begin
            state   <= RELEASE;
            i_gnt_q <= 1'b0;
            d_gnt_q <= 1'b0;
          end
        end
        RELEASE: state <= IDLE;
        default: begin
          state   <= IDLE;
          i_gnt_q <= 1'b0;
          d_gnt_q <= 1'b0;
        end
      endcase
    end
  end

  assign i_gnt = i_gnt_q;
  assign d_gnt = d_gnt_q;
  assign err   = err_q;

  // Refill bursts always walk the block from word 0; stores use their own word.
  assign mem_req   = xfer;
  assign mem_we    = in_d && we;
  assign mem_addr  = !xfer ? '0 :
                     we    ? {word_addr, 2'b00} :
                             {word_addr[ADDR_W-1:IW+2], beat_cnt, 2'b00};
  assign mem_wdata = (in_d && we) ? wdata : 32'd0;

  assign i_rvalid   = in_i && mem_ready;
  assign d_rvalid   = in_d && mem_ready && !we;
  assign i_rdata    = i_rvalid ? mem_rdata : 32'd0;
  assign d_rdata    = d_rvalid ? mem_rdata : 32'd0;
  assign i_word_idx = i_rvalid ? beat_cnt : '0;
  assign d_word_idx = d_rvalid ? beat_cnt : '0;
  assign i_done     = in_i && finish;
  assign d_done     = in_d && finish;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised self-checking bench for mem_port_arbiter against a
// transaction-level model of bursts, round-robin grants and the watchdog.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int BW  = 4;
  localparam int TMO = 8;

  logic        CLK = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done;
  logic        mem_req, mem_we, err;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0]  i_word_idx, d_word_idx;
  logic [140:0] all_out;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_err;
  bit last_d;

  always #5 CLK = ~CLK;

  assign all_out = {i_gnt, i_rvalid, i_rdata, i_word_idx, i_done,
                    d_gnt, d_rvalid, d_rdata, d_word_idx, d_done,
                    mem_req, mem_we, mem_addr, mem_wdata, err};

  mem_port_arbiter #(.ADDR_W(AW), .BLOCK_WORDS(BW), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_word_idx(i_word_idx), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_word_idx(d_word_idx), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err(err)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; mem_rdata = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    exp_err = 1'b0;
    last_d = 1'b1;
  endtask

  // One granted transfer from its first granted cycle through RELEASE.
  task automatic run_xfer(input bit side, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int pct, input int fixed_wait,
                          input bit keep_req, output int ncyc);
    int k; int idle; int cyc; bit fin; bit rdy; bit exp_done;
    logic [31:0] exp_addr; logic [31:0] rdata_drv;
    k = 0; idle = 0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 100) begin
      rdy = (fixed_wait >= 0) ? (cyc >= fixed_wait) : ($urandom_range(0, 99) < pct);
      rdata_drv = $urandom;
      mem_ready = rdy;
      mem_rdata = rdata_drv;
      @(negedge CLK);
      exp_addr = we ? (addr & 32'hFFFF_FFFC) : ((addr & 32'hFFFF_FFF0) + 32'(k * 4));
      if (rdy) idle = 0; else idle++;
      exp_done = rdy ? (we || k == BW - 1) : (idle == TMO);
      n_cmp++; if ({i_gnt, d_gnt} !== (side ? 2'b01 : 2'b10)) begin n_bad++; $display("FAIL gnt: got %b want %b", {i_gnt, d_gnt}, side ? 2'b01 : 2'b10); end
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL mem_req: got %b want 1", mem_req); end
      n_cmp++; if (mem_addr !== exp_addr) begin n_bad++; $display("FAIL mem_addr: got %h want %h", mem_addr, exp_addr); end
      n_cmp++; if (mem_we !== we) begin n_bad++; $display("FAIL mem_we: got %b want %b", mem_we, we); end
      if (we) begin
        n_cmp++; if (mem_wdata !== wdata) begin n_bad++; $display("FAIL mem_wdata: got %h want %h", mem_wdata, wdata); end
      end
      n_cmp++; if ({i_rvalid, d_rvalid} !== ((rdy && !we) ? (side ? 2'b01 : 2'b10) : 2'b00)) begin n_bad++; $display("FAIL rvalid: got %b rdy=%b we=%b", {i_rvalid, d_rvalid}, rdy, we); end
      if (rdy && !we) begin
        n_cmp++; if ((side ? d_rdata : i_rdata) !== rdata_drv) begin n_bad++; $display("FAIL rdata: got %h want %h", side ? d_rdata : i_rdata, rdata_drv); end
        n_cmp++; if ((side ? d_word_idx : i_word_idx) !== 2'(k)) begin n_bad++; $display("FAIL word_idx: got %0d want %0d", side ? d_word_idx : i_word_idx, k); end
      end
      n_cmp++; if ({i_done, d_done} !== (exp_done ? (side ? 2'b01 : 2'b10) : 2'b00)) begin n_bad++; $display("FAIL done: got %b want done=%b side=%b", {i_done, d_done}, exp_done, side); end
      n_cmp++; if (err !== exp_err) begin n_bad++; $display("FAIL err: got %b want %b", err, exp_err); end
      if (!rdy && exp_done) exp_err = 1'b1;
      if (rdy && !we) k++;
      fin = exp_done;
      cyc++;
      tick();
    end
    n_cmp++; if (!fin) begin n_bad++; $display("FAIL xfer_budget: got %0d cycles without done want fewer than 100", cyc); end
    ncyc = cyc;
    if (!keep_req) begin
      if (side) d_req = 1'b0; else i_req = 1'b0;
    end
    mem_ready = 1'b1;
    mem_rdata = $urandom;
    @(negedge CLK);
    n_cmp++; if ({i_gnt, d_gnt, mem_req, i_rvalid, d_rvalid, i_done, d_done} !== 7'd0) begin n_bad++; $display("FAIL release: got %b want 0000000", {i_gnt, d_gnt, mem_req, i_rvalid, d_rvalid, i_done, d_done}); end
    n_cmp++; if (err !== exp_err) begin n_bad++; $display("FAIL release_err: got %b want %b", err, exp_err); end
    tick();
    mem_ready = 1'b0;
  endtask

  // Called in IDLE with the request already raised: one sampling cycle, then the grant.
  task automatic serve(input bit side, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int pct, input int fixed_wait,
                       input bit keep_req, output int ncyc);
    @(negedge CLK);
    n_cmp++; if ({i_gnt, d_gnt, mem_req} !== 3'b000) begin n_bad++; $display("FAIL idle_gnt: got %b want 000", {i_gnt, d_gnt, mem_req}); end
    tick();
    run_xfer(side, we, addr, wdata, pct, fixed_wait, keep_req, ncyc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; mem_ready = 1'b1;
    i_addr = 32'hFFFF_FFFF; d_addr = 32'hFFFF_FFFF; d_wdata = 32'hFFFF_FFFF; mem_rdata = 32'hFFFF_FFFF;
    #2;
    n_cmp++; if (all_out !== 141'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    apply_reset();
    @(negedge CLK);
    n_cmp++; if (all_out !== 141'd0) begin n_bad++; $display("FAIL post_reset_idle: got %h want 0", all_out); end
    tick();
  endtask

  task automatic test_refill();
    int n;
    i_addr = 32'h0000_0104;
    i_req = 1'b1;
    serve(1'b0, 1'b0, i_addr, 32'd0, 100, -1, 1'b0, n);
    n_cmp++; if (n !== BW) begin n_bad++; $display("FAIL refill_len: got %0d want %0d", n, BW); end
    last_d = 1'b0;
  endtask

  task automatic test_round_robin();
    int n;
    apply_reset();
    i_addr = $urandom; d_addr = $urandom; d_we = 1'b0; d_wdata = $urandom;
    i_req = 1'b1; d_req = 1'b1;
    serve(1'b0, 1'b0, i_addr, 32'd0, 100, -1, 1'b0, n);
    serve(1'b1, 1'b0, d_addr, d_wdata, 100, -1, 1'b0, n);
    last_d = 1'b1;
  endtask

  task automatic test_write_through();
    int n;
    d_addr = 32'h0000_0203; d_wdata = 32'hDEAD_BEEF; d_we = 1'b1;
    d_req = 1'b1;
    serve(1'b1, 1'b1, d_addr, d_wdata, 0, 3, 1'b0, n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL wt_hold: got %0d want 4", n); end
    last_d = 1'b1;
    d_we = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    i_addr = $urandom;
    i_req = 1'b1;
    serve(1'b0, 1'b0, i_addr, 32'd0, 0, -1, 1'b0, n);
    n_cmp++; if (n !== TMO) begin n_bad++; $display("FAIL timeout_len: got %0d want %0d", n, TMO); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", err); end
    d_addr = $urandom; d_we = 1'b0;
    d_req = 1'b1;
    serve(1'b1, 1'b0, d_addr, 32'd0, 100, -1, 1'b0, n);
    last_d = 1'b1;
  endtask

  task automatic test_idle_ready();
    int n;
    mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mem_rdata = $urandom;
      @(negedge CLK);
      n_cmp++; if ({i_rvalid, d_rvalid, mem_req, i_done, d_done} !== 5'd0) begin n_bad++; $display("FAIL idle_ready: got %b want 00000", {i_rvalid, d_rvalid, mem_req, i_done, d_done}); end
      tick();
    end
    mem_ready = 1'b0;
    i_addr = $urandom;
    i_req = 1'b1;
    serve(1'b0, 1'b0, i_addr, 32'd0, 100, -1, 1'b1, n);
    serve(1'b0, 1'b0, i_addr, 32'd0, 100, -1, 1'b0, n);
    last_d = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    d_addr = $urandom; d_we = 1'b0;
    d_req = 1'b1;
    @(negedge CLK);
    tick();
    mem_ready = 1'b1;
    tick();
    tick();
    #1;
    n_cmp++; if (mem_addr !== ((d_addr & 32'hFFFF_FFF0) + 32'd8)) begin n_bad++; $display("FAIL beat2_addr: got %h want %h", mem_addr, (d_addr & 32'hFFFF_FFF0) + 32'd8); end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (all_out !== 141'd0) begin n_bad++; $display("FAIL async_abort: got %h want 0", all_out); end
    mem_ready = 1'b0;
    d_req = 1'b0;
    tick();
    rst = 1'b0;
    exp_err = 1'b0;
    last_d = 1'b1;
    d_addr = $urandom;
    d_req = 1'b1;
    serve(1'b1, 1'b0, d_addr, 32'd0, 100, -1, 1'b0, n);
  endtask

  task automatic test_random();
    int n; int pat; int pct; bit first; bit dwe;
    logic [31:0] ia; logic [31:0] da; logic [31:0] dw;
    for (int it = 0; it < 12; it++) begin
      pat = $urandom_range(1, 3);
      pct = $urandom_range(50, 100);
      dwe = 1'($urandom_range(0, 1));
      ia = $urandom; da = $urandom; dw = $urandom;
      i_addr = ia; d_addr = da; d_we = dwe; d_wdata = dw;
      i_req = pat[0]; d_req = pat[1];
      if (pat == 3) first = last_d ? 1'b0 : 1'b1;
      else first = (pat == 2);
      serve(first, first ? dwe : 1'b0, first ? da : ia, dw, pct, -1, 1'b0, n);
      last_d = first;
      if (pat == 3) begin
        serve(!first, !first ? dwe : 1'b0, !first ? da : ia, dw, pct, -1, 1'b0, n);
        last_d = !first;
      end
    end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_round_robin();
    test_write_through();
    test_timeout();
    test_idle_ready();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
